// File: rtl/instr_loader_if.sv
// Host byte-stream channel into the instruction loader: valid/ready handshake
// carrying one program byte plus an end-of-program marker.
interface instr_loader_if;
  logic       i_byte_valid;
  logic [7:0] i_byte;
  logic       i_last;
  logic       o_byte_ready;

  modport master (output i_byte_valid, i_byte, i_last, input o_byte_ready);
  modport slave  (input i_byte_valid, i_byte, i_last, output o_byte_ready);
endinterface

// File: rtl/instr_loader.sv
// Instruction BRAM write-side front end: pairs host bytes into 16-bit words,
// writes them at sequential addresses from 0 and reports session status.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          HI_FIRST   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  instr_loader_if.slave         byte_if,
  output logic                  o_en_write,
  output logic [ADDR_WIDTH-1:0] o_addr_write,
  output logic [15:0]           o_instr_write,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_error
);

  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state, state_nx;
  logic [7:0]            first_r, first_nx;
  logic                  last_r, last_nx;
  logic [CW-1:0]         count_nx;
  logic                  error_nx;
  logic                  en_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [15:0]           instr_nx;
  logic                  ready_nx, busy_nx, done_nx;
  logic                  xfer;

  // Next-state and next-output decode; status flags follow the next state so
  // they are registered yet aligned with it.
  always_comb begin
    state_nx = state;
    first_nx = first_r;
    last_nx  = last_r;
    count_nx = o_count;
    error_nx = o_error;
    en_nx    = 1'b0;
    addr_nx  = o_addr_write;
    instr_nx = o_instr_write;
    xfer     = byte_if.i_byte_valid && byte_if.o_byte_ready;

    case (state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_nx = S_HI;
          count_nx = '0;
          error_nx = 1'b0;
        end
      end
      S_HI: begin
        if (xfer) begin
          first_nx = byte_if.i_byte;
          if (byte_if.i_last) begin
            error_nx = 1'b1;
            state_nx = S_DONE;
          end else begin
            state_nx = S_LO;
          end
        end
      end
      S_LO: begin
        // The write is staged here so the enable, address and data registers
        // present it during the single WR cycle.
        if (xfer) begin
          last_nx  = byte_if.i_last;
          state_nx = S_WR;
          en_nx    = 1'b1;
          addr_nx  = o_count[ADDR_WIDTH-1:0];
          instr_nx = HI_FIRST ? {first_r, byte_if.i_byte} : {byte_if.i_byte, first_r};
        end
      end
      S_WR: begin
        count_nx = o_count + CW'(1);
        if (last_r) begin
          state_nx = S_DONE;
        end else if (count_nx == CW'(DEPTH)) begin
          error_nx = 1'b1;
          state_nx = S_DONE;
        end else begin
          state_nx = S_HI;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    ready_nx = (state_nx == S_HI) || (state_nx == S_LO);
    busy_nx  = ready_nx || (state_nx == S_WR);
    done_nx  = (state_nx == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                <= S_IDLE;
      first_r              <= '0;
      last_r               <= 1'b0;
      o_count              <= '0;
      o_error              <= 1'b0;
      o_en_write           <= 1'b0;
      o_addr_write         <= '0;
      o_instr_write        <= '0;
      o_busy               <= 1'b0;
      o_done               <= 1'b0;
      byte_if.o_byte_ready <= 1'b0;
    end else begin
      state                <= state_nx;
      first_r              <= first_nx;
      last_r               <= last_nx;
      o_count              <= count_nx;
      o_error              <= error_nx;
      o_en_write           <= en_nx;
      o_addr_write         <= addr_nx;
      o_instr_write        <= instr_nx;
      o_busy               <= busy_nx;
      o_done               <= done_nx;
      byte_if.o_byte_ready <= ready_nx;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: drives identical byte streams into a
// HI_FIRST=1 and a HI_FIRST=0 instance and checks writes and status.
module tb_instr_loader;

  logic       i_clk = 1'b0;
  logic       rst, start, valid, last;
  logic [7:0] bval;

  always #5 i_clk = ~i_clk;

  instr_loader_if bus_h ();
  instr_loader_if bus_l ();

  assign bus_h.i_byte_valid = valid;
  assign bus_h.i_byte       = bval;
  assign bus_h.i_last       = last;
  assign bus_l.i_byte_valid = valid;
  assign bus_l.i_byte       = bval;
  assign bus_l.i_last       = last;

  logic        en_h, en_l, busy_h, busy_l, done_h, done_l, err_h, err_l;
  logic [7:0]  addr_h, addr_l;
  logic [15:0] instr_h, instr_l;
  logic [8:0]  count_h, count_l;

  instr_loader #(.ADDR_WIDTH(8), .HI_FIRST(1'b1)) dut_h (
    .i_clk(i_clk), .i_rst(rst), .i_start(start), .byte_if(bus_h),
    .o_en_write(en_h), .o_addr_write(addr_h), .o_instr_write(instr_h),
    .o_busy(busy_h), .o_done(done_h), .o_count(count_h), .o_error(err_h));

  instr_loader #(.ADDR_WIDTH(8), .HI_FIRST(1'b0)) dut_l (
    .i_clk(i_clk), .i_rst(rst), .i_start(start), .byte_if(bus_l),
    .o_en_write(en_l), .o_addr_write(addr_l), .o_instr_write(instr_l),
    .o_busy(busy_l), .o_done(done_l), .o_count(count_l), .o_error(err_l));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  wa_h[$], wa_l[$];
  logic [15:0] wd_h[$], wd_l[$];
  int          wc_h[$];

  always @(posedge i_clk) cyc++;

  // Write log captured mid-cycle, away from the active edge
  always @(negedge i_clk) begin
    if (en_h === 1'b1) begin
      wa_h.push_back(addr_h);
      wd_h.push_back(instr_h);
      wc_h.push_back(cyc);
    end
    if (en_l === 1'b1) begin
      wa_l.push_back(addr_l);
      wd_l.push_back(instr_l);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_log();
    wa_h.delete(); wa_l.delete(); wd_h.delete(); wd_l.delete(); wc_h.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present a byte with valid high and hold it until a handshake edge passes
  task automatic send(input logic [7:0] b, input logic l);
    int n;
    n     = 0;
    valid = 1'b1;
    bval  = b;
    last  = l;
    while (!(bus_h.o_byte_ready === 1'b1 && bus_l.o_byte_ready === 1'b1) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(n), 32'(0));
    step();
  endtask

  task automatic status(input string tag, input logic bz, input logic dn,
                        input logic [8:0] cnt, input logic er, input logic rd);
    chk({tag, "_busy_h"},  32'(busy_h),  32'(bz));
    chk({tag, "_busy_l"},  32'(busy_l),  32'(bz));
    chk({tag, "_done_h"},  32'(done_h),  32'(dn));
    chk({tag, "_done_l"},  32'(done_l),  32'(dn));
    chk({tag, "_count_h"}, 32'(count_h), 32'(cnt));
    chk({tag, "_count_l"}, 32'(count_l), 32'(cnt));
    chk({tag, "_error_h"}, 32'(err_h),   32'(er));
    chk({tag, "_error_l"}, 32'(err_l),   32'(er));
    chk({tag, "_ready_h"}, 32'(bus_h.o_byte_ready), 32'(rd));
    chk({tag, "_ready_l"}, 32'(bus_l.o_byte_ready), 32'(rd));
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_en_h"},    32'(en_h),    32'(0));
    chk({tag, "_en_l"},    32'(en_l),    32'(0));
    chk({tag, "_addr_h"},  32'(addr_h),  32'(0));
    chk({tag, "_addr_l"},  32'(addr_l),  32'(0));
    chk({tag, "_instr_h"}, 32'(instr_h), 32'(0));
    chk({tag, "_instr_l"}, 32'(instr_l), 32'(0));
    status(tag, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
  endtask

  task automatic check_two_writes(input string tag);
    chk({tag, "_nwr_h"}, 32'(wa_h.size()), 32'(2));
    chk({tag, "_nwr_l"}, 32'(wa_l.size()), 32'(2));
    if (wa_h.size() >= 2 && wa_l.size() >= 2) begin
      chk({tag, "_a0_h"}, 32'(wa_h[0]), 32'h0);
      chk({tag, "_d0_h"}, 32'(wd_h[0]), 32'h1234);
      chk({tag, "_a1_h"}, 32'(wa_h[1]), 32'h1);
      chk({tag, "_d1_h"}, 32'(wd_h[1]), 32'h5678);
      chk({tag, "_a0_l"}, 32'(wa_l[0]), 32'h0);
      chk({tag, "_d0_l"}, 32'(wd_l[0]), 32'h3412);
      chk({tag, "_a1_l"}, 32'(wa_l[1]), 32'h1);
      chk({tag, "_d1_l"}, 32'(wd_l[1]), 32'h7856);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat [4];
    int         gaps [4];
    logic [7:0] a, b;
    pat  = '{8'h12, 8'h34, 8'h56, 8'h78};
    gaps = '{1, 4, 2, 3};

    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; bval = 8'h00;
    step(); step();
    zero_outputs("reset");

    // Bytes offered in IDLE are not accepted
    rst = 1'b0; valid = 1'b1; bval = 8'h99;
    step(); step();
    valid = 1'b0;
    status("idle", 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    chk("idle_nwr", 32'(wa_h.size() + wa_l.size()), 32'(0));

    // Basic load, valid held high
    clear_log();
    pulse_start();
    status("start", 1'b1, 1'b0, 9'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(pat[i], i == 3);
    valid = 1'b0; last = 1'b0;
    step(); step(); step();
    check_two_writes("basic");
    if (wc_h.size() >= 2) chk("basic_spacing", 32'(wc_h[1] - wc_h[0]), 32'(3));
    status("basic_end", 1'b0, 1'b1, 9'd2, 1'b0, 1'b0);

    // Restart from DONE, stalls between bytes
    clear_log();
    pulse_start();
    status("restart", 1'b1, 1'b0, 9'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(pat[i], i == 3);
      valid = 1'b0; last = 1'b0;
      for (int g = 0; g < gaps[i]; g++) begin
        step();
        if (i < 3) begin
          chk("gap_ready_h", 32'(bus_h.o_byte_ready), 32'(1));
          chk("gap_ready_l", 32'(bus_l.o_byte_ready), 32'(1));
        end
      end
    end
    step();
    check_two_writes("stall");
    status("stall_end", 1'b0, 1'b1, 9'd2, 1'b0, 1'b0);

    // Odd byte count
    clear_log();
    pulse_start();
    send(8'hAB, 1'b1);
    valid = 1'b0; last = 1'b0;
    step(); step();
    chk("odd_nwr", 32'(wa_h.size() + wa_l.size()), 32'(0));
    status("odd", 1'b0, 1'b1, 9'd0, 1'b1, 1'b0);

    // Overflow: 512 bytes with no end marker
    clear_log();
    pulse_start();
    for (int i = 0; i < 512; i++) send(8'(i), 1'b0);
    valid = 1'b0;
    step(); step();
    chk("ovf_nwr_h", 32'(wa_h.size()), 32'(256));
    chk("ovf_nwr_l", 32'(wa_l.size()), 32'(256));
    if (wa_h.size() == 256 && wa_l.size() == 256) begin
      for (int k = 0; k < 256; k++) begin
        a = 8'(2 * k);
        b = 8'(2 * k + 1);
        chk("ovf_addr_h", 32'(wa_h[k]), 32'(k));
        chk("ovf_data_h", 32'(wd_h[k]), 32'({a, b}));
        chk("ovf_data_l", 32'(wd_l[k]), 32'({b, a}));
      end
    end
    status("ovf", 1'b0, 1'b1, 9'd256, 1'b1, 1'b0);

    // Exactly 256 words with the end marker on the final byte
    clear_log();
    pulse_start();
    for (int i = 0; i < 512; i++) send(8'(i), i == 511);
    valid = 1'b0; last = 1'b0;
    step(); step();
    chk("full_nwr_h", 32'(wa_h.size()), 32'(256));
    chk("full_nwr_l", 32'(wa_l.size()), 32'(256));
    if (wa_h.size() == 256 && wa_l.size() == 256) begin
      chk("full_last_addr", 32'(wa_h[255]), 32'hFF);
      chk("full_last_d_h",  32'(wd_h[255]), 32'hFEFF);
      chk("full_last_d_l",  32'(wd_l[255]), 32'hFFFE);
    end
    status("full", 1'b0, 1'b1, 9'd256, 1'b0, 1'b0);

    // Reset after the first byte of a pair
    clear_log();
    pulse_start();
    send(8'h11, 1'b0);
    valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    zero_outputs("midrst");
    step(); step();
    chk("midrst_nwr", 32'(wa_h.size() + wa_l.size()), 32'(0));

    // Reset wins over a coincident start
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    status("rst_start", 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);

    // Start mid-pair is ignored; the pair still lands at address 0
    clear_log();
    pulse_start();
    send(8'hCA, 1'b0);
    valid = 1'b0;
    pulse_start();
    send(8'hFE, 1'b1);
    valid = 1'b0; last = 1'b0;
    step(); step();
    chk("ign_nwr_h", 32'(wa_h.size()), 32'(1));
    chk("ign_nwr_l", 32'(wa_l.size()), 32'(1));
    if (wa_h.size() == 1 && wa_l.size() == 1) begin
      chk("ign_addr_h", 32'(wa_h[0]), 32'h0);
      chk("ign_data_h", 32'(wd_h[0]), 32'hCAFE);
      chk("ign_data_l", 32'(wd_l[0]), 32'hFECA);
    end
    status("ign", 1'b0, 1'b1, 9'd1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Write-side front end for the instruction BRAM.
- Accepts a byte stream from the host link (UART/debug path) over a valid/ready handshake and assembles byte pairs into 16-bit instructions.
- Drives the BRAM write port (write enable, address, data) with sequential addresses from 0.
- Reports session status (busy, done, word count, error) to the control/boot logic that releases the CPU after program load.

Parameters:
- ADDR_WIDTH, 8, BRAM address width; depth = 2**ADDR_WIDTH words (256).
- HI_FIRST, 1, byte order: 1 = first byte of a pair is instr[15:8]; 0 = first byte is instr[7:0].

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle pulse that begins a load session; honoured only in IDLE or DONE.
- i_byte_valid  input  1  i_byte is valid this cycle.
- i_byte  input  8  incoming program byte.
- i_last  input  1  qualifies i_byte as the final byte of the program; sampled only on a handshake.
- o_byte_ready  output  1  loader can accept a byte this cycle.
- o_en_write  output  1  BRAM write enable, one-cycle pulse per instruction.
- o_addr_write  output  ADDR_WIDTH  BRAM write address.
- o_instr_write  output  16  BRAM write data.
- o_busy  output  1  session in progress (states HI, LO, WR).
- o_done  output  1  session finished; held until the next i_start or reset.
- o_count  output  ADDR_WIDTH+1  number of instructions written this session (0..256).
- o_error  output  1  session ended abnormally (odd byte count or overflow); held with o_done.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous, active-high.
- Reset (any state, including mid-session): state goes to IDLE. All outputs, o_count, and the internal hi/lo/last registers clear to 0. No write is issued in the reset cycle or the following cycle.
- Handshake: a byte transfers when i_byte_valid && o_byte_ready at a clock edge. o_byte_ready is a pure decode of the registered state (1 in HI and LO only), never combinational from the inputs. i_byte and i_last are ignored without a handshake.
- IDLE: o_byte_ready=0. On i_start, go to HI and clear o_count, o_error, o_done.
- HI: on handshake, capture the first byte.
  - If i_last=1: set o_error=1 (odd byte count), go to DONE, no write.
  - Otherwise go to LO.
- LO: on handshake, capture the second byte and the i_last flag, then go to WR.
- WR (exactly one cycle): o_en_write=1, o_addr_write=o_count[ADDR_WIDTH-1:0], o_instr_write = {first,second} if HI_FIRST=1, else {second,first}. At the same edge, o_count increments.
  - If the captured last flag is set, go to DONE.
  - Else if o_count becomes 2**ADDR_WIDTH, set o_error=1 (overflow) and go to DONE.
  - Else go to HI.
- DONE: o_done=1, o_byte_ready=0. Remains in DONE until i_start, which goes to HI and clears count, error and done.
- i_start is ignored in HI, LO and WR.
- o_en_write is 0 in every state except WR. o_addr_write and o_instr_write hold their last values between writes (0 after reset).
- Minimum throughput: 3 cycles per instruction with i_byte_valid held high. Gaps in valid stall in HI or LO indefinitely without side effects.
- Address never wraps: the write at address 255 is the last possible write. A program of exactly 256 words with i_last on the final byte ends with o_error=0. Without i_last on that byte it ends with o_error=1.
- i_start and i_rst in the same cycle: reset wins.

Test Plan:
- Reset: assert i_rst 2 cycles from a random state -> all outputs 0, state IDLE, o_byte_ready=0.
- Basic load: i_start, then bytes 0x12, 0x34, 0x56, 0x78 (i_last on 0x78) with valid held high -> o_en_write pulses twice: addr 0 data 0x1234, then addr 1 data 0x5678. Result o_count=2, o_done=1, o_error=0. Pulses are 3 cycles apart.
- Stalls and HI_FIRST=0: same bytes with 1–4 idle cycles between them -> writes 0x3412@0 and 0x7856@1, no extra writes, o_byte_ready stays high during the gaps.
- Odd byte count: i_start, byte 0xAB with i_last -> no o_en_write, o_error=1, o_done=1, o_count=0.
- Overflow and boundary: i_start, 512 bytes with no i_last -> 256 writes at addr 0..255, o_count=256, o_error=1, o_done=1, o_byte_ready=0 afterwards. Repeat with i_last on byte 512 -> o_error=0.
- Reset mid-session and restart: reset after the first byte of the pair -> no write, IDLE. Separately, i_start in DONE -> o_count, o_error, o_done clear and the next pair writes to addr 0.
